rom_port_arbiter: RTL and testbench
===================================

// Module: rom_port_arbiter
// PURPOSE
// - Shares the single-port instruction ROM between two requesters: M0 = core instruction fetch (read-only)
//   and M1 = debug/UART program downloader (read/write).
// - Sits between the two bus masters and the ROM. Issues at most one ROM access per cycle.
// - Returns a registered, one-cycle-latency ack and data to the owning master.
// - Supports a download lock and stalls the core pipeline via hold_flag_o while M1 owns the ROM.
// PARAMETERS
// - ROM_DEPTH   4096   number of 32-bit words; word index = addr[31:2]
// - M1_FIRST    1      tie-break winner on the first contention after reset (1 = M1, 0 = M0)
// PORTS
// - clk          in   1   single clock, all logic on posedge
// - rst          in   1   synchronous, active-high reset
// - m0_req_i     in   1   fetch request, held until m0_ack_o
// - m0_addr_i    in   32  fetch byte address
// - m0_data_o    out  32  read data, valid when m0_ack_o=1
// - m0_ack_o     out  1   one-cycle completion pulse
// - m1_req_i     in   1   downloader request, held until m1_ack_o
// - m1_we_i      in   1   1 = write, 0 = read
// - m1_addr_i    in   32  byte address
// - m1_data_i    in   32  write data
// - m1_lock_i    in   1   keep ROM ownership across accesses (burst download)
// - m1_data_o    out  32  read data, valid when m1_ack_o=1
// - m1_ack_o     out  1   one-cycle completion pulse
// - rom_we_o     out  1   ROM write enable
// - rom_addr_o   out  32  ROM byte address
// - rom_data_o   out  32  ROM write data
// - rom_data_i   in   32  ROM combinational read data
// - hold_flag_o  out  1   core stall request, high while M1 owns or holds the lock
// BEHAVIOUR
// - Reset (sync, rst=1):
//   - All outputs go to 0; state <= IDLE; last-grant pointer <= !M1_FIRST.
//   - Any access in flight is dropped with no ack.
// - States: IDLE, M0_OWN, M1_OWN, M1_LOCK. State is registered; grant is decided combinationally from state and requests.
// - Eligibility: a master is eligible when its req is high AND its ack_o is low this cycle. This prevents duplicate grants.
// - Arbitration:
//   - IDLE / M0_OWN / M1_OWN: if one master is eligible, grant it. If both are eligible, round-robin: grant the master not granted last.
//   - M1_LOCK: only M1 may be granted. M0 waits, its req is ignored, no timeout.
// - Grant cycle N:
//   - rom_addr_o = granted addr; rom_we_o = m1_we_i, only when M1 is granted and in range.
//   - Write commits at posedge ending N.
//   - rom_data_i is captured at that edge for reads.
//   - ack of the granted master = 1 in N+1 for exactly 1 cycle.
//   - Its data_o is the captured word (0 for writes).
// - No grant in a cycle: rom_we_o=0; rom_addr_o holds its last value.
// - Range:
//   - addr[31:2] >= ROM_DEPTH: read returns 32'h0; write suppressed (rom_we_o=0).
//   - Ack is still given. Out-of-range accesses never hang.
// - Lock:
//   - M1_OWN -> M1_LOCK when M1 is granted with m1_lock_i=1.
//   - M1_LOCK -> IDLE on the first cycle with m1_lock_i=0 and no M1 grant.
// - hold_flag_o:
//   - Registered.
//   - 1 in every cycle after an M1 grant, through the lock.
//   - Drops the cycle after the state leaves M1_OWN/M1_LOCK.
// - Throughput: per master, 1 access per 2 cycles; aggregate 1 per cycle when M0 and M1 interleave.
// - Simultaneous events:
//   - A new M0 request arriving in the same cycle as m1_lock_i rising while M1 is granted: M1 wins and the lock takes effect.
//   - rst overrides everything.
// STRUCTURE
// - defines.v holds the shared constants: MemBus/MemAddrBus widths, ZeroWord, state encodings ARB_IDLE..ARB_M1_LOCK, master IDs ARB_M0/ARB_M1.
// - One sub-module, rr_arb2: 2-way round-robin picker.
//   - Inputs: clk, rst, req[1:0], en.
//   - Outputs: gnt[1:0] (one-hot/zero).
//   - Holds the last-grant pointer. en=0 masks M0 in the lock state.
// - Everything else (state register, ack/data capture, range check, hold flag) stays in rom_port_arbiter.
// TESTING
// - M0 only, ROM[4]=32'hDEADBEEF, m0 addr 0x10 held -> rom_addr_o=0x10 in N; m0_ack_o=1, m0_data_o=DEADBEEF in N+1; next grant N+2.
// - M1 write 0x20 <- 32'h12345678, then M0 read 0x20 -> rom_we_o=1 exactly 1 cycle; M0 later reads 12345678; hold_flag_o=1 only after the M1 grant.
// - Both requesting continuously with M1_FIRST=1 -> grants alternate M1,M0,M1,M0; each ack arrives 1 cycle after its grant; never two acks in one cycle.
// - M1 lock burst: m1_lock_i=1, 4 writes 0x0..0xC while m0_req_i=1 -> M0 gets no ack until the cycle after lock drops; hold_flag_o high throughout.
// - Out-of-range write to 0x4000 (ROM_DEPTH=4096) -> rom_we_o=0, m1_ack_o=1, m1_data_o=0; a read there returns 0.
// - rst=1 in the ack cycle of an M0 read -> m0_ack_o=0 next cycle; state IDLE; hold_flag_o=0; a fresh M0 request after reset completes normally.

Source files
------------

// File: rtl/rom_port_arbiter_pkg.sv
// Shared constants, state encodings and helpers for the instruction-ROM port arbiter.
package rom_port_arbiter_pkg;

    localparam int MEM_BUS_W      = 32;
    localparam int MEM_ADDR_BUS_W = 32;
    localparam logic [MEM_BUS_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_M0_OWN  = 2'd1,
        ARB_M1_OWN  = 2'd2,
        ARB_M1_LOCK = 2'd3
    } arb_state_t;

    localparam int ARB_M0 = 0;
    localparam int ARB_M1 = 1;

    // Word index (byte address >> 2) checked against the ROM depth in words.
    function automatic logic word_in_range(input logic [29:0] word_idx, input int depth);
        logic [31:0] lim;
        lim = depth;
        return {2'b00, word_idx} < lim;
    endfunction

endpackage

// File: rtl/rom_port_arbiter_rr_arb2.sv
// Two-way round-robin picker; remembers which master was granted last.
module rr_arb2 #(
    parameter bit M1_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);
    import rom_port_arbiter_pkg::*;

    logic       last_m1;
    logic [1:0] req_eff;

    // en=0 hides M0 entirely so a locked M1 can never lose the port.
    always_comb begin
        req_eff = {req[ARB_M1], req[ARB_M0] & en};
        gnt     = req_eff;
        if (req_eff == 2'b11) begin
            gnt = last_m1 ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_m1 <= !M1_FIRST;
        end else if (gnt[ARB_M1]) begin
            last_m1 <= 1'b1;
        end else if (gnt[ARB_M0]) begin
            last_m1 <= 1'b0;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the single-port instruction ROM between core fetch (M0) and the debug downloader (M1).
module rom_port_arbiter #(
    parameter int ROM_DEPTH = 4096,
    parameter int M1_FIRST  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    input  logic        m1_lock_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        rom_we_o,
    output logic [31:0] rom_addr_o,
    output logic [31:0] rom_data_o,
    input  logic [31:0] rom_data_i,
    output logic        hold_flag_o
);
    import rom_port_arbiter_pkg::*;

    arb_state_t  state;
    arb_state_t  state_next;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        gnt_m0;
    logic        gnt_m1;
    logic        en;
    logic [31:0] sel_addr;
    logic        sel_in_range;
    logic [31:0] addr_hold;

    // A master whose ack is out this cycle is not eligible, so a held req is never granted twice.
    assign req = {m1_req_i & ~m1_ack_o & ~rst, m0_req_i & ~m0_ack_o & ~rst};
    assign en  = (state != ARB_M1_LOCK);

    rr_arb2 #(
        .M1_FIRST(M1_FIRST != 0)
    ) u_rr_arb2 (
        .clk(clk),
        .rst(rst),
        .req(req),
        .en (en),
        .gnt(gnt)
    );

    assign gnt_m0       = gnt[ARB_M0];
    assign gnt_m1       = gnt[ARB_M1];
    assign sel_addr     = gnt_m1 ? m1_addr_i : m0_addr_i;
    assign sel_in_range = word_in_range(sel_addr[31:2], ROM_DEPTH);

    assign rom_addr_o = (gnt_m0 | gnt_m1) ? sel_addr : addr_hold;
    assign rom_we_o   = gnt_m1 & m1_we_i & sel_in_range;
    assign rom_data_o = gnt_m1 ? m1_data_i : ZERO_WORD;

    always_comb begin
        state_next = state;
        case (state)
            ARB_M1_LOCK: begin
                if (gnt_m1) begin
                    state_next = ARB_M1_LOCK;
                end else if (!m1_lock_i) begin
                    state_next = ARB_IDLE;
                end
            end
            default: begin
                if (gnt_m1) begin
                    state_next = m1_lock_i ? ARB_M1_LOCK : ARB_M1_OWN;
                end else if (gnt_m0) begin
                    state_next = ARB_M0_OWN;
                end else begin
                    state_next = ARB_IDLE;
                end
            end
        endcase
    end

    // Grant cycle -> ack/data cycle boundary: ROM word captured on the edge ending the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ARB_IDLE;
            hold_flag_o <= 1'b0;
            addr_hold   <= ZERO_WORD;
            m0_ack_o    <= 1'b0;
            m0_data_o   <= ZERO_WORD;
            m1_ack_o    <= 1'b0;
            m1_data_o   <= ZERO_WORD;
        end else begin
            state       <= state_next;
            hold_flag_o <= gnt_m1 | (state == ARB_M1_OWN) | (state == ARB_M1_LOCK);
            addr_hold   <= rom_addr_o;
            m0_ack_o    <= gnt_m0;
            m1_ack_o    <= gnt_m1;
            if (gnt_m0) begin
                m0_data_o <= sel_in_range ? rom_data_i : ZERO_WORD;
            end
            if (gnt_m1) begin
                m1_data_o <= (sel_in_range && !m1_we_i) ? rom_data_i : ZERO_WORD;
            end
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a behavioural 4K-word ROM behind the port.
module tb_rom_port_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req_i;
    logic [31:0] m0_addr_i;
    logic [31:0] m0_data_o;
    logic        m0_ack_o;
    logic        m1_req_i;
    logic        m1_we_i;
    logic [31:0] m1_addr_i;
    logic [31:0] m1_data_i;
    logic        m1_lock_i;
    logic [31:0] m1_data_o;
    logic        m1_ack_o;
    logic        rom_we_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_o;
    logic [31:0] rom_data_i;
    logic        hold_flag_o;

    logic        preload;
    logic [31:0] mem [0:4095];
    int          n_checks;
    int          n_errs;

    rom_port_arbiter #(
        .ROM_DEPTH(4096),
        .M1_FIRST (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_req_i   (m0_req_i),
        .m0_addr_i  (m0_addr_i),
        .m0_data_o  (m0_data_o),
        .m0_ack_o   (m0_ack_o),
        .m1_req_i   (m1_req_i),
        .m1_we_i    (m1_we_i),
        .m1_addr_i  (m1_addr_i),
        .m1_data_i  (m1_data_i),
        .m1_lock_i  (m1_lock_i),
        .m1_data_o  (m1_data_o),
        .m1_ack_o   (m1_ack_o),
        .rom_we_o   (rom_we_o),
        .rom_addr_o (rom_addr_o),
        .rom_data_o (rom_data_o),
        .rom_data_i (rom_data_i),
        .hold_flag_o(hold_flag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM model: combinational read (aliases above 16 KB), write on the clock edge.
    assign rom_data_i = mem[rom_addr_o[13:2]];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'h5A00_0000 | 32'(i);
            mem[4] <= 32'hDEAD_BEEF;
        end else if (rom_we_o) begin
            mem[rom_addr_o[13:2]] <= rom_data_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errs    = 0;
        rst       = 1'b1;
        preload   = 1'b1;
        m0_req_i  = 1'b0;
        m0_addr_i = '0;
        m1_req_i  = 1'b0;
        m1_we_i   = 1'b0;
        m1_addr_i = '0;
        m1_data_i = '0;
        m1_lock_i = 1'b0;
        next_cycle();
        preload = 1'b0;
        next_cycle();

        // Reset state
        check("rst_m0_ack", m0_ack_o, 0);
        check("rst_m1_ack", m1_ack_o, 0);
        check("rst_hold", hold_flag_o, 0);
        check("rst_we", rom_we_o, 0);
        check("rst_addr", rom_addr_o, 0);
        check("rst_m0_data", m0_data_o, 0);
        rst = 1'b0;

        // M0 only, held request: grant N, ack N+1, next grant N+2
        m0_req_i  = 1'b1;
        m0_addr_i = 32'h10;
        settle();
        check("t1_addr_n", rom_addr_o, 32'h10);
        check("t1_we_n", rom_we_o, 0);
        next_cycle();
        check("t1_ack_n1", m0_ack_o, 1);
        check("t1_data_n1", m0_data_o, 32'hDEAD_BEEF);
        next_cycle();
        check("t1_ack_n2", m0_ack_o, 0);
        check("t1_addr_n2", rom_addr_o, 32'h10);
        next_cycle();
        check("t1_ack_n3", m0_ack_o, 1);
        m0_req_i = 1'b0;
        next_cycle();
        check("t1_ack_idle", m0_ack_o, 0);

        // M1 write then M0 read-back of the same word
        m1_req_i  = 1'b1;
        m1_we_i   = 1'b1;
        m1_addr_i = 32'h20;
        m1_data_i = 32'h1234_5678;
        settle();
        check("t2_we_n", rom_we_o, 1);
        check("t2_addr_n", rom_addr_o, 32'h20);
        check("t2_wdata_n", rom_data_o, 32'h1234_5678);
        check("t2_hold_n", hold_flag_o, 0);
        next_cycle();
        check("t2_m1_ack", m1_ack_o, 1);
        check("t2_m1_data", m1_data_o, 0);
        check("t2_hold_n1", hold_flag_o, 1);
        m1_req_i  = 1'b0;
        m1_we_i   = 1'b0;
        m0_req_i  = 1'b1;
        m0_addr_i = 32'h20;
        settle();
        check("t2_we_n1", rom_we_o, 0);
        check("t2_m0_addr", rom_addr_o, 32'h20);
        next_cycle();
        check("t2_m0_ack", m0_ack_o, 1);
        check("t2_m0_data", m0_data_o, 32'h1234_5678);
        check("t2_m1_ack_off", m1_ack_o, 0);
        check("t2_hold_n2", hold_flag_o, 1);
        m0_req_i = 1'b0;
        next_cycle();
        check("t2_hold_drop", hold_flag_o, 0);

        // Both masters continuously: M1,M0,M1,M0,... after reset
        rst = 1'b1;
        next_cycle();
        rst       = 1'b0;
        m0_req_i  = 1'b1;
        m0_addr_i = 32'h10;
        m1_req_i  = 1'b1;
        m1_we_i   = 1'b0;
        m1_addr_i = 32'h20;
        for (int i = 0; i < 6; i++) begin
            settle();
            check($sformatf("t3_grant%0d", i), rom_addr_o, (i % 2 == 0) ? 32'h20 : 32'h10);
            check($sformatf("t3_m1_ack%0d", i), m1_ack_o, (i % 2 == 1) ? 1 : 0);
            check($sformatf("t3_m0_ack%0d", i), m0_ack_o, (i > 0 && i % 2 == 0) ? 1 : 0);
            if (m1_ack_o) check($sformatf("t3_m1_data%0d", i), m1_data_o, 32'h1234_5678);
            if (m0_ack_o) check($sformatf("t3_m0_data%0d", i), m0_data_o, 32'hDEAD_BEEF);
            next_cycle();
        end
        check("t3_last_m0_ack", m0_ack_o, 1);
        check("t3_last_m1_ack", m1_ack_o, 0);
        m0_req_i = 1'b0;
        m1_req_i = 1'b0;

        // Locked burst of 4 writes with M0 requesting throughout
        rst = 1'b1;
        next_cycle();
        rst       = 1'b0;
        m0_req_i  = 1'b1;
        m0_addr_i = 32'h10;
        m1_req_i  = 1'b1;
        m1_we_i   = 1'b1;
        m1_lock_i = 1'b1;
        m1_addr_i = 32'h0;
        m1_data_i = 32'h1000_0000;
        for (int k = 0; k < 4; k++) begin
            settle();
            check($sformatf("t4_we%0d", k), rom_we_o, 1);
            check($sformatf("t4_addr%0d", k), rom_addr_o, 32'(4 * k));
            check($sformatf("t4_hold_g%0d", k), hold_flag_o, (k > 0) ? 1 : 0);
            check($sformatf("t4_m0_ack_g%0d", k), m0_ack_o, 0);
            next_cycle();
            check($sformatf("t4_m1_ack%0d", k), m1_ack_o, 1);
            check($sformatf("t4_m0_ack_a%0d", k), m0_ack_o, 0);
            check($sformatf("t4_hold_a%0d", k), hold_flag_o, 1);
            if (k < 3) begin
                m1_addr_i = 32'(4 * (k + 1));
                m1_data_i = 32'h1000_0000 + 32'(k + 1);
            end else begin
                m1_req_i  = 1'b0;
                m1_lock_i = 1'b0;
                m1_we_i   = 1'b0;
            end
            settle();
            check($sformatf("t4_idle_we%0d", k), rom_we_o, 0);
            check($sformatf("t4_idle_addr%0d", k), rom_addr_o, 32'(4 * k));
            next_cycle();
        end
        check("t4_unlock_hold", hold_flag_o, 1);
        check("t4_unlock_m0_ack", m0_ack_o, 0);
        settle();
        check("t4_m0_grant", rom_addr_o, 32'h10);
        next_cycle();
        check("t4_m0_ack", m0_ack_o, 1);
        check("t4_m0_data", m0_data_o, 32'hDEAD_BEEF);
        check("t4_hold_off", hold_flag_o, 0);
        m0_req_i = 1'b0;

        // Out-of-range write and read at 0x4000, then read word 0 back
        m1_req_i  = 1'b1;
        m1_we_i   = 1'b1;
        m1_addr_i = 32'h4000;
        m1_data_i = 32'hFFFF_FFFF;
        settle();
        check("t5_we_oor", rom_we_o, 0);
        check("t5_addr_oor", rom_addr_o, 32'h4000);
        next_cycle();
        check("t5_wr_ack", m1_ack_o, 1);
        check("t5_wr_data", m1_data_o, 0);
        m1_we_i = 1'b0;
        next_cycle();
        check("t5_rd_addr", rom_addr_o, 32'h4000);
        next_cycle();
        check("t5_rd_ack", m1_ack_o, 1);
        check("t5_rd_data", m1_data_o, 0);
        m1_addr_i = 32'h0;
        next_cycle();
        next_cycle();
        check("t5_w0_ack", m1_ack_o, 1);
        check("t5_w0_data", m1_data_o, 32'h1000_0000);
        m1_req_i = 1'b0;
        next_cycle();

        // Reset during the ack cycle, then during a grant cycle
        m0_req_i  = 1'b1;
        m0_addr_i = 32'h10;
        next_cycle();
        check("t6_ack_before_rst", m0_ack_o, 1);
        rst = 1'b1;
        next_cycle();
        check("t6_ack_after_rst", m0_ack_o, 0);
        check("t6_data_after_rst", m0_data_o, 0);
        check("t6_hold_after_rst", hold_flag_o, 0);
        rst = 1'b0;
        settle();
        check("t6_fresh_addr", rom_addr_o, 32'h10);
        next_cycle();
        check("t6_fresh_ack", m0_ack_o, 1);
        check("t6_fresh_data", m0_data_o, 32'hDEAD_BEEF);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        check("t6_drop_ack", m0_ack_o, 0);
        rst      = 1'b0;
        m0_req_i = 1'b0;
        next_cycle();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
